// File: rtl/hyperspace_frame_seq_if.sv
// Byte-source, core-input and core-output-monitor signals of the HyperSpace frame sequencer.
// The master modport is the sequencer's view; slave is the surrounding source/core view.
interface hyperspace_frame_seq_if;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       core_in_valid;
    logic [7:0] core_in_data;
    logic       core_in_last;
    logic       core_in_ready;
    logic       core_out_valid;
    logic       core_out_ready;
    logic       core_out_last;

    modport master (
        input  src_valid, src_data, core_in_ready,
        input  core_out_valid, core_out_ready, core_out_last,
        output src_ready, core_in_valid, core_in_data, core_in_last
    );

    modport slave (
        output src_valid, src_data, core_in_ready,
        output core_out_valid, core_out_ready, core_out_last,
        input  src_ready, core_in_valid, core_in_data, core_in_last
    );
endinterface

// File: rtl/hyperspace_frame_seq.sv
// Frame sequencer: admits IN_LEN bytes per frame into the HyperSpace core, waits for OUT_LEN output beats.
// Optional HYPERSPACE_SEQ_PERF_EN adds lat_cycles (first input handshake to final output beat).
module hyperspace_frame_seq #(
    parameter int IN_LEN  = 2048,
    parameter int OUT_LEN = 1536,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535,
    parameter int TO_W    = 16
) (
    input  logic                     clock,
    input  logic                     RSTB,
    input  logic                     start,
    input  logic                     abort,
    input  logic [7:0]               num_frames,
    hyperspace_frame_seq_if.master   io,
    output logic                     busy,
    output logic                     done,
    output logic [7:0]               frame_cnt,
    output logic                     err_last,
    output logic                     err_timeout
`ifdef HYPERSPACE_SEQ_PERF_EN
    ,
    output logic [23:0]              lat_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

    localparam logic [CNT_W-1:0] IN_END  = CNT_W'(IN_LEN - 1);
    localparam logic [CNT_W-1:0] OUT_END = CNT_W'(OUT_LEN - 1);
    localparam logic [TO_W-1:0]  TO_END  = TO_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             out_done;
    logic [7:0]       nf_q;

    logic feeding, draining, in_hs, beat, at_out_end, final_beat;
    logic out_complete, frame_done, last_frame;

    always_comb begin
        feeding      = (state == FEED);
        draining     = (state == DRAIN);
        in_hs        = feeding & io.src_valid & io.core_in_ready;
        beat         = (feeding | draining) & io.core_out_valid & io.core_out_ready;
        at_out_end   = (out_cnt == OUT_END);
        final_beat   = beat & ~out_done & at_out_end;
        out_complete = out_done | final_beat;
        // A frame closes on its last input byte if the output side already finished, else in DRAIN.
        frame_done   = (in_hs & (in_cnt == IN_END) & out_complete) | (draining & out_complete);
        last_frame   = (nf_q != 8'd0) && ((frame_cnt + 8'd1) == nf_q);
    end

    assign io.src_ready     = feeding & io.core_in_ready;
    assign io.core_in_valid = feeding & io.src_valid;
    assign io.core_in_data  = feeding ? io.src_data : 8'd0;
    assign io.core_in_last  = feeding & (in_cnt == IN_END);

    always_ff @(posedge clock) begin
        if (RSTB) begin
            state       <= IDLE;
            in_cnt      <= '0;
            out_cnt     <= '0;
            to_cnt      <= '0;
            out_done    <= 1'b0;
            nf_q        <= 8'd0;
            frame_cnt   <= 8'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            to_cnt    <= '0;
            out_done  <= 1'b0;
            frame_cnt <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // Output beats are tracked in FEED too, since the core may answer before its input ends.
            if (beat) begin
                if (out_done) begin
                    err_last <= 1'b1;
                end else begin
                    if (io.core_out_last != at_out_end)
                        err_last <= 1'b1;
                    if (at_out_end) begin
                        out_cnt  <= '0;
                        out_done <= 1'b1;
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                end
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= FEED;
                        busy        <= 1'b1;
                        nf_q        <= num_frames;
                        frame_cnt   <= 8'd0;
                        err_last    <= 1'b0;
                        err_timeout <= 1'b0;
                        in_cnt      <= '0;
                        out_cnt     <= '0;
                        to_cnt      <= '0;
                        out_done    <= 1'b0;
                    end
                end
                FEED: begin
                    if (in_hs) begin
                        if (in_cnt == IN_END) begin
                            in_cnt <= '0;
                            if (!frame_done) begin
                                state  <= DRAIN;
                                to_cnt <= '0;
                            end
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (!frame_done) begin
                        if (beat) begin
                            to_cnt <= '0;
                        end else if (to_cnt == TO_END) begin
                            to_cnt      <= '0;
                            err_timeout <= 1'b1;
                            state       <= IDLE;
                            busy        <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (frame_done) begin
                frame_cnt <= frame_cnt + 8'd1;
                out_done  <= 1'b0;
                if (last_frame) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end else begin
                    state <= FEED;
                end
            end
        end
    end

`ifdef HYPERSPACE_SEQ_PERF_EN
    logic [23:0] lat_acc;
    logic [23:0] lat_frz;
    logic [23:0] lat_now;
    logic        lat_run;

    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == 24'hFF_FFFF) ? v : v + 24'd1;
    endfunction

    assign lat_now = lat_run ? lat_acc : 24'd0;

    // lat_frz holds the latency when the output side finishes before the input side.
    always_ff @(posedge clock) begin
        if (RSTB) begin
            lat_run    <= 1'b0;
            lat_acc    <= 24'd0;
            lat_frz    <= 24'd0;
            lat_cycles <= 24'd0;
        end else if (abort) begin
            lat_run <= 1'b0;
            lat_acc <= 24'd0;
            lat_frz <= 24'd0;
        end else begin
            if (final_beat) begin
                lat_frz <= lat_now;
                lat_run <= 1'b0;
            end else if (in_hs && (in_cnt == '0) && !lat_run) begin
                lat_run <= 1'b1;
                lat_acc <= 24'd1;
            end else if (lat_run) begin
                lat_acc <= sat_inc(lat_acc);
            end
            if (frame_done)
                lat_cycles <= final_beat ? lat_now : lat_frz;
        end
    end
`endif

endmodule

// File: tb/tb_hyperspace_frame_seq.sv
// Directed bench for hyperspace_frame_seq using short frames so every scenario, including the drain timeout, runs quickly.
module tb_hyperspace_frame_seq;
    localparam int IN_LEN  = 16;
    localparam int OUT_LEN = 12;
    localparam int TIMEOUT = 40;

    logic       clock;
    logic       RSTB;
    logic       start;
    logic       abort;
    logic [7:0] num_frames;
    logic       busy;
    logic       done;
    logic [7:0] frame_cnt;
    logic       err_last;
    logic       err_timeout;

    hyperspace_frame_seq_if io();

    hyperspace_frame_seq #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .CNT_W(16), .TIMEOUT(TIMEOUT), .TO_W(16)
    ) dut (
        .clock(clock), .RSTB(RSTB), .start(start), .abort(abort), .num_frames(num_frames),
        .io(io), .busy(busy), .done(done), .frame_cnt(frame_cnt),
        .err_last(err_last), .err_timeout(err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run() call
    int         r_in, r_beats, r_lasts, r_lerr, r_viol, r_done, r_idle;
    bit         r_hung, r_fc1_seen, r_sr1, r_done1;
    logic [7:0] r_fc1, r_fc_last;

    // Pulses start, then plays source and core stub cycle by cycle until the run ends.
    // Core beats of frame f are released once (r_in + IN_LEN - lag) / IN_LEN > f.
    task automatic run(input int nf, input int lag, input bit half_v, input bit tog_r,
                       input int bad_at, input int stop_at, input int abort_at, input int max_cyc);
        int fa;
        bit hs, bt, drain, ab;
        r_in = 0; r_beats = 0; r_lasts = 0; r_lerr = 0; r_viol = 0; r_done = 0; r_idle = 0;
        r_hung = 0; r_fc1_seen = 0; r_sr1 = 0; r_done1 = 0; r_fc1 = 8'd0; r_fc_last = 8'd0;
        num_frames = 8'(nf);
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            fa = (r_in + IN_LEN - lag) / IN_LEN;
            io.src_valid      = half_v ? (cyc % 2 == 0) : 1'b1;
            io.src_data       = 8'(r_in * 7 + 3);
            io.core_out_valid = (r_beats < fa * OUT_LEN) && (r_beats < stop_at);
            io.core_out_ready = tog_r ? (cyc % 3 != 2) : 1'b1;
            io.core_out_last  = (r_beats % OUT_LEN == OUT_LEN - 1) || (r_beats == bad_at);
            ab    = (abort_at >= 0) && (r_in == abort_at);
            abort = ab;
            #4;
            drain = busy && (r_in > 0) && (r_in % IN_LEN == 0) && (r_beats < (r_in / IN_LEN) * OUT_LEN);
            hs    = io.src_valid && io.src_ready;
            bt    = io.core_out_valid && io.core_out_ready;
            if (!busy || drain) begin
                if (io.src_ready || io.core_in_valid || io.core_in_last) r_viol++;
            end else if (io.core_in_valid !== io.src_valid || io.src_ready !== io.core_in_ready ||
                         (io.src_valid && io.core_in_data !== io.src_data) ||
                         io.core_in_last !== (r_in % IN_LEN == IN_LEN - 1)) begin
                r_lerr++;
            end
            if (hs && io.core_in_last) r_lasts++;
            if (drain && !bt) r_idle++;
            if (done) r_done++;
            if (r_in == IN_LEN && !r_fc1_seen) begin
                r_fc1_seen = 1; r_fc1 = frame_cnt; r_sr1 = io.src_ready; r_done1 = done;
            end
            r_fc_last = frame_cnt;
            if (hs) r_in++;
            if (bt) r_beats++;
            @(posedge clock); #1;
            if (ab) begin
                abort = 1'b0;
                return;
            end
            if (!busy && !done) return;
        end
        r_hung = 1;
    endtask

    task automatic test_reset;
        RSTB = 1'b1; start = 1'b1; abort = 1'b0; num_frames = 8'd1;
        io.src_valid = 1'b1; io.src_data = 8'hA5; io.core_in_ready = 1'b1;
        io.core_out_valid = 1'b0; io.core_out_ready = 1'b1; io.core_out_last = 1'b0;
        repeat (3) @(posedge clock);
        #1; RSTB = 1'b0; start = 1'b0;
        #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (frame_cnt !== 8'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if ({err_last, err_timeout} !== 2'b00) begin errors++; $display("FAIL reset_errs: got %b expected 00", {err_last, err_timeout}); end
        checks++; if ({io.src_ready, io.core_in_valid, io.core_in_last} !== 3'b000) begin errors++; $display("FAIL reset_hs: got %b expected 000", {io.src_ready, io.core_in_valid, io.core_in_last}); end
        checks++; if (io.core_in_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %h expected 00", io.core_in_data); end
    endtask

    task automatic test_single_frame;
        run(1, IN_LEN, 0, 0, -1, 1 << 20, -1, 500);
        checks++; if (r_hung) begin errors++; $display("FAIL single_hung: got 1 expected 0"); end
        checks++; if (r_in !== IN_LEN) begin errors++; $display("FAIL single_in: got %0d expected %0d", r_in, IN_LEN); end
        checks++; if (r_beats !== OUT_LEN) begin errors++; $display("FAIL single_beats: got %0d expected %0d", r_beats, OUT_LEN); end
        checks++; if (r_lasts !== 1) begin errors++; $display("FAIL single_lasts: got %0d expected 1", r_lasts); end
        checks++; if (r_lerr !== 0 || r_viol !== 0) begin errors++; $display("FAIL single_path: got %0d/%0d expected 0/0", r_lerr, r_viol); end
        checks++; if (r_done !== 1) begin errors++; $display("FAIL single_done: got %0d expected 1", r_done); end
        checks++; if (frame_cnt !== 8'd1) begin errors++; $display("FAIL single_frame_cnt: got %0d expected 1", frame_cnt); end
        checks++; if ({err_last, err_timeout, busy} !== 3'b000) begin errors++; $display("FAIL single_flags: got %b expected 000", {err_last, err_timeout, busy}); end
    endtask

    task automatic test_multi_frame;
        run(3, 12, 1, 1, -1, 1 << 20, -1, 1000);
        checks++; if (r_hung) begin errors++; $display("FAIL multi_hung: got 1 expected 0"); end
        checks++; if (r_in !== 3 * IN_LEN) begin errors++; $display("FAIL multi_in: got %0d expected %0d", r_in, 3 * IN_LEN); end
        checks++; if (r_beats !== 3 * OUT_LEN) begin errors++; $display("FAIL multi_beats: got %0d expected %0d", r_beats, 3 * OUT_LEN); end
        checks++; if (r_lasts !== 3) begin errors++; $display("FAIL multi_lasts: got %0d expected 3", r_lasts); end
        checks++; if (r_viol !== 0 || r_lerr !== 0) begin errors++; $display("FAIL multi_drain_ready: got %0d/%0d expected 0/0", r_viol, r_lerr); end
        checks++; if (frame_cnt !== 8'd3) begin errors++; $display("FAIL multi_frame_cnt: got %0d expected 3", frame_cnt); end
        checks++; if (r_done !== 1) begin errors++; $display("FAIL multi_done: got %0d expected 1", r_done); end
    endtask

    task automatic test_err_last;
        run(1, IN_LEN, 0, 0, 5, 1 << 20, -1, 500);
        checks++; if (r_done !== 1 || frame_cnt !== 8'd1) begin errors++; $display("FAIL errlast_completes: got done %0d frames %0d expected 1 1", r_done, frame_cnt); end
        repeat (3) @(posedge clock);
        #1;
        checks++; if (err_last !== 1'b1) begin errors++; $display("FAIL errlast_sticky: got %b expected 1", err_last); end
        num_frames = 8'd1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; #3;
        checks++; if ({err_last, busy} !== 2'b01) begin errors++; $display("FAIL errlast_cleared: got %b expected 01", {err_last, busy}); end
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
    endtask

    task automatic test_same_cycle;
        run(2, 4, 0, 0, -1, 1 << 20, -1, 500);
        checks++; if (r_fc1 !== 8'd1 || r_sr1 !== 1'b1) begin errors++; $display("FAIL same2_after_first: got frames %0d ready %0d expected 1 1", r_fc1, r_sr1); end
        checks++; if (frame_cnt !== 8'd2 || r_done !== 1) begin errors++; $display("FAIL same2_end: got frames %0d done %0d expected 2 1", frame_cnt, r_done); end
        checks++; if (r_viol !== 0 || r_lerr !== 0 || err_last !== 1'b0) begin errors++; $display("FAIL same2_path: got %0d/%0d/%b expected 0/0/0", r_viol, r_lerr, err_last); end
        run(1, 4, 0, 0, -1, 1 << 20, -1, 500);
        checks++; if (r_done1 !== 1'b1 || r_fc1 !== 8'd1) begin errors++; $display("FAIL same1_done_next: got done %0d frames %0d expected 1 1", r_done1, r_fc1); end
        checks++; if (frame_cnt !== 8'd1 || r_done !== 1) begin errors++; $display("FAIL same1_end: got frames %0d done %0d expected 1 1", frame_cnt, r_done); end
    endtask

    task automatic test_timeout;
        run(1, IN_LEN, 0, 0, -1, 8, -1, 500);
        checks++; if (r_hung) begin errors++; $display("FAIL timeout_hung: got 1 expected 0"); end
        checks++; if (r_idle !== TIMEOUT) begin errors++; $display("FAIL timeout_idle_cycles: got %0d expected %0d", r_idle, TIMEOUT); end
        checks++; if ({err_timeout, busy} !== 2'b10) begin errors++; $display("FAIL timeout_flags: got %b expected 10", {err_timeout, busy}); end
        checks++; if (r_done !== 0 || frame_cnt !== 8'd0) begin errors++; $display("FAIL timeout_no_done: got done %0d frames %0d expected 0 0", r_done, frame_cnt); end
    endtask

    task automatic test_rstb_midrun;
        num_frames = 8'd0; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; #3;
        checks++; if ({busy, err_timeout} !== 2'b10) begin errors++; $display("FAIL rstb_started: got %b expected 10", {busy, err_timeout}); end
        @(posedge clock); #1;
        RSTB = 1'b1;
        @(posedge clock); #1;
        RSTB = 1'b0; #3;
        checks++; if ({busy, io.src_ready, frame_cnt} !== 10'd0) begin errors++; $display("FAIL rstb_midrun: got %b expected 0", {busy, io.src_ready, frame_cnt}); end
    endtask

    task automatic test_abort;
        run(0, 4, 0, 0, -1, 1 << 20, IN_LEN + 5, 500);
        checks++; if (r_hung || r_fc_last !== 8'd1) begin errors++; $display("FAIL abort_before: got hung %0d frames %0d expected 0 1", r_hung, r_fc_last); end
        io.src_valid = 1'b1; #3;
        checks++; if ({busy, io.src_ready, io.core_in_valid} !== 3'b000) begin errors++; $display("FAIL abort_idle: got %b expected 000", {busy, io.src_ready, io.core_in_valid}); end
        num_frames = 8'd1; start = 1'b1; abort = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; abort = 1'b0; #3;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_vs_start: got %b expected 0", busy); end
        run(1, IN_LEN, 0, 0, -1, 1 << 20, -1, 500);
        checks++; if (r_lasts !== 1 || r_lerr !== 0 || r_in !== IN_LEN) begin errors++; $display("FAIL abort_restart: got lasts %0d lerr %0d in %0d expected 1 0 %0d", r_lasts, r_lerr, r_in, IN_LEN); end
        checks++; if (frame_cnt !== 8'd1 || r_done !== 1) begin errors++; $display("FAIL abort_restart_end: got frames %0d done %0d expected 1 1", frame_cnt, r_done); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_multi_frame();
        test_err_last();
        test_same_cycle();
        test_timeout();
        test_rstb_midrun();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
